// File: rtl/muldiv_seq.sv
// muldiv_seq: 32-bit sequential multiply/divide unit with HI/LO registers.
// A radix-2 datapath runs 32 iterations, then one sign-fix cycle.
// Signed operands are converted to magnitudes when the operation is accepted.
module muldiv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd3;
  localparam logic [3:0] OP_MULTU = 4'd4;
  localparam logic [3:0] OP_DIV   = 4'd5;
  localparam logic [3:0] OP_DIVU  = 4'd6;

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t      state, state_nxt;
  logic [63:0] acc;       // product, or {remainder, quotient}
  logic [31:0] opnd;      // multiplicand or divisor magnitude
  logic [5:0]  cnt;
  logic        is_div;
  logic        neg_a;     // dividend/multiplicand was negative (signed ops only)
  logic        neg_res;   // operand signs differ (signed ops only)
  logic        div0;

  logic        valid_op, is_signed, accept;
  logic        sa, sb;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, div_diff;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix, a_raw;

  assign valid_op  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  assign is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign accept    = start && valid_op && ((state == IDLE) || (state == DONE));
  assign sa        = is_signed && a[31];
  assign sb        = is_signed && b[31];
  assign a_mag     = sa ? (~a + 32'd1) : a;
  assign b_mag     = sb ? (~b + 32'd1) : b;

  // Shift-add adds the multiplicand to the upper half when the multiplier LSB is set.
  // The restoring subtract is 33 bits wide, so bit 32 indicates a borrow.
  assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
  assign div_diff = acc[63:31] - {1'b0, opnd};

  // Sign correction applied in FIX.
  assign prod_fix = neg_res ? (~acc + 64'd1) : acc;
  assign quo_fix  = neg_res ? (~acc[31:0] + 32'd1) : acc[31:0];
  assign rem_fix  = neg_a ? (~acc[63:32] + 32'd1) : acc[63:32];
  // Divide-by-zero leaves the dividend magnitude untouched, so re-sign it to recover a.
  assign a_raw    = neg_a ? (~acc[31:0] + 32'd1) : acc[31:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and status outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = ITER;
      ITER: begin
        busy = 1'b1;
        if (cnt == 6'd31) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = accept ? ITER : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, one iteration per ITER cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      opnd    <= '0;
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_a   <= 1'b0;
      neg_res <= 1'b0;
      div0    <= 1'b0;
    end else if (accept) begin
      acc     <= (op == OP_DIV || op == OP_DIVU) ? {32'd0, a_mag} : {32'd0, b_mag};
      opnd    <= (op == OP_DIV || op == OP_DIVU) ? b_mag : a_mag;
      cnt     <= '0;
      is_div  <= (op == OP_DIV) || (op == OP_DIVU);
      neg_a   <= sa;
      neg_res <= sa ^ sb;
      div0    <= (b == 32'd0);
    end else if (state == ITER) begin
      cnt <= cnt + 6'd1;
      if (!is_div)
        acc <= {mul_sum, acc[31:1]};
      else if (!div0) begin
        if (div_diff[32]) acc <= {acc[62:0], 1'b0};
        else              acc <= {div_diff[31:0], acc[30:0], 1'b1};
      end
    end
  end

  // HI/LO: result write on FIX->DONE, otherwise MTHI/MTLO when not busy
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (state == FIX) begin
      if (!is_div) begin
        hi <= prod_fix[63:32];
        lo <= prod_fix[31:0];
      end else if (div0) begin
        hi <= a_raw;
        lo <= 32'hFFFF_FFFF;
      end else begin
        hi <= rem_fix;
        lo <= quo_fix;
      end
    end else if (!busy) begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq.
module tb_muldiv_seq;
  logic        clk = 1'b0;
  logic        rst, start, hi_we, lo_we;
  logic [3:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;
  int          total = 0;
  int          bad   = 0;
  logic        saw_done;

  muldiv_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Advance past one rising edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accept at cycle N, check busy over N+1..N+33, done and result at N+34.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic we, input logic [31:0] wd,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    op = o; a = av; b = bv; start = 1'b1;
    hi_we = we; lo_we = we; wdata = wd;
    tick();
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    chk({tag, " busy@N+1"}, {31'd0, busy}, 32'd1);
    if (we) begin
      chk({tag, " mthi@accept"}, hi, wd);
      chk({tag, " mtlo@accept"}, lo, wd);
    end
    repeat (32) tick();
    chk({tag, " busy@N+33"}, {31'd0, busy}, 32'd1);
    chk({tag, " done@N+33"}, {31'd0, done}, 32'd0);
    tick();
    chk({tag, " done@N+34"}, {31'd0, done}, 32'd1);
    chk({tag, " busy@N+34"}, {31'd0, busy}, 32'd0);
    chk({tag, " hi"}, hi, exp_hi);
    chk({tag, " lo"}, lo, exp_lo);
    tick();
    chk({tag, " done@N+35"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 4'd0; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    tick(); tick();
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    rst = 1'b0;

    // MTHI/MTLO while idle
    hi_we = 1'b1; wdata = 32'h0000_AAAA;
    tick();
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h0000_5555;
    tick();
    lo_we = 1'b0;
    chk("mthi idle", hi, 32'h0000_AAAA);
    chk("mtlo idle", lo, 32'h0000_5555);

    // Invalid op with start is ignored
    op = 4'd7; start = 1'b1;
    tick();
    op = 4'd2;
    tick();
    start = 1'b0;
    chk("invalid op busy", {31'd0, busy}, 32'd0);

    run_op("multu max", 4'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'hFFFF_FFFE, 32'h0000_0001);
    // MTHI/MTLO coinciding with accept land first, then the result overwrites them
    run_op("mult -3*5", 4'd3, 32'hFFFF_FFFD, 32'd5, 1'b1, 32'h0000_DEAD, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("div -7/2", 4'd5, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu 7/0", 4'd6, 32'd7, 32'd0, 1'b0, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF);
    run_op("div min/-1", 4'd5, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h0000_0000, 32'h8000_0000);
    run_op("div -9/0", 4'd5, 32'hFFFF_FFF7, 32'd0, 1'b0, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF);
    run_op("div 100/-7", 4'd5, 32'd100, 32'hFFFF_FFF9, 1'b0, 32'd0, 32'h0000_0002, 32'hFFFF_FFF2);

    // Interference: start and MTHI during an operation are ignored (HI currently 2)
    op = 4'd6; a = 32'd100; b = 32'd7; start = 1'b1;
    tick();                       // N+1
    start = 1'b0;
    repeat (4) tick();            // N+5
    op = 4'd4; a = 32'd3; b = 32'd3; start = 1'b1;
    tick();                       // N+6
    start = 1'b0; hi_we = 1'b1; wdata = 32'h0000_1234;
    tick();                       // N+7
    hi_we = 1'b0;
    chk("intf hi unchanged", hi, 32'h0000_0002);
    chk("intf busy", {31'd0, busy}, 32'd1);
    repeat (26) tick();           // N+33
    chk("intf done@N+33", {31'd0, done}, 32'd0);
    tick();                       // N+34
    chk("intf done@N+34", {31'd0, done}, 32'd1);
    chk("intf lo", lo, 32'd14);
    chk("intf hi", hi, 32'd2);
    tick();

    // Reset mid-operation, with start/hi_we also asserted on the reset edge
    op = 4'd4; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    tick();                       // N+1
    start = 1'b0;
    repeat (9) tick();            // N+10
    rst = 1'b1; start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_0005;
    tick();                       // N+11
    rst = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst hi", hi, 32'd0);
    chk("midrst lo", lo, 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    chk("midrst no done", {31'd0, saw_done}, 32'd0);
    chk("midrst hi after", hi, 32'd0);
    chk("midrst lo after", lo, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameters: none; datapath width is fixed at 32 bits.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin an operation; sampled on clk.
REQ-005 op  input  4  ALU control code: 3=MULT, 4=MULTU, 5=DIV, 6=DIVU; other codes are invalid.
REQ-006 a  input  32  operand A (multiplicand or dividend), sampled only on the accept cycle.
REQ-007 b  input  32  operand B (multiplier or divisor), sampled only on the accept cycle.
REQ-008 hi_we  input  1  MTHI write enable.
REQ-009 lo_we  input  1  MTLO write enable.
REQ-010 wdata  input  32  data for MTHI/MTLO.
REQ-011 busy  output  1  operation in progress; the pipeline stalls MFHI/MFLO while high.
REQ-012 done  output  1  one-cycle pulse when the result is written.
REQ-013 hi  output  32  HI register (product high word or remainder).
REQ-014 lo  output  32  LO register (product low word or quotient).

Function
REQ-015 FSM states SHALL be IDLE, ITER, FIX and DONE.
REQ-016 Accept SHALL occur when start=1, op is in {3,4,5,6}, and the state is IDLE or DONE.
REQ-017 On accept, the block SHALL latch op, sign flags and operand magnitudes (unsigned ops use the raw values), clear the 6-bit iteration counter, and enter ITER.
REQ-018 start with an invalid op SHALL be ignored, and the state SHALL become or remain IDLE.
REQ-019 start while in ITER or FIX SHALL be ignored, with no queuing.
REQ-020 ITER SHALL last exactly 32 cycles: one radix-2 shift-add (multiply) or restoring shift-subtract (divide) step per cycle, then go to FIX.
REQ-021 FIX SHALL last 1 cycle and apply sign correction for signed ops:
  - Product: negate the 64-bit value if the operand signs differ.
  - Quotient: negate if the signs differ.
  - Remainder: take the sign of the dividend.
REQ-022 The FIX->DONE edge SHALL write hi/lo.
REQ-023 DONE SHALL last 1 cycle, then go to IDLE unless a new accept occurs.
REQ-024 Latency: accept at cycle N SHALL give busy=1 in cycles N+1..N+33, done=1 and the new hi/lo visible in cycle N+34.
REQ-025 busy SHALL be 1 exactly in ITER and FIX; done SHALL be 1 exactly in DONE.
REQ-026 Divide by zero (b=0) SHALL give lo=0xFFFFFFFF and hi=a unmodified, for both DIV and DIVU, with the same latency.
REQ-027 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000, with no trap.
REQ-028 hi_we/lo_we SHALL write wdata on the next edge only when busy=0.
REQ-029 hi_we/lo_we SHALL be ignored while busy=1.
REQ-030 If hi_we/lo_we coincides with an accept, the write SHALL take effect and the later result SHALL overwrite it.
REQ-031 Internal accumulator width: 64-bit product/remainder register plus a 32-bit operand register.
REQ-032 The divider subtract SHALL be 33 bits wide so the borrow is detected.

Reset
REQ-033 rst=1 at any edge SHALL force: state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
REQ-034 Reset mid-operation SHALL abandon the operation, and hi/lo SHALL remain 0 afterwards.
REQ-035 rst SHALL take priority over start, hi_we and lo_we in the same cycle.

Verification
REQ-036 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> cycle N+34: done=1, hi=0xFFFFFFFE, lo=0x00000001.
REQ-037 MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-038 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-039 DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=0x00000007; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-040 Interference sequence -> each input SHALL be ignored:
  - Start DIVU 100/7.
  - Assert start with MULTU at cycle N+5.
  - Assert hi_we with wdata=0x1234 at cycle N+6.
  - Required result: done at N+34 with lo=14, hi=2.
REQ-041 Start MULTU, assert rst at cycle N+10 -> next cycle busy=0, hi=lo=0, and no done pulse follows.
